// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite style word-addressed SRAM slave with independent read and write FSMs.
// Byte-strobed writes; OKAY in range, SLVERR out of range.
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t    r_rstate;
    w_state_t    r_wstate;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_awaddr;

    // Offset from the base wraps for addresses below BASE_ADDR, so one
    // unsigned compare covers both ends of the window.
    logic [31:0]      w_ar_off;
    logic [31:0]      w_aw_off;
    logic             w_ar_hit;
    logic             w_aw_hit;
    logic [IDX_W-1:0] w_ar_idx;
    logic [IDX_W-1:0] w_aw_idx;
    logic             w_ar_hs;
    logic             w_w_hs;

    assign w_ar_off = araddr - BASE_ADDR;
    assign w_aw_off = r_awaddr - BASE_ADDR;
    assign w_ar_hit = (w_ar_off < SPAN);
    assign w_aw_hit = (w_aw_off < SPAN);
    assign w_ar_idx = w_ar_off[IDX_W+1:2];
    assign w_aw_idx = w_aw_off[IDX_W+1:2];
    assign w_ar_hs  = arvalid && r_arready;
    assign w_w_hs   = wvalid && r_wready;

    // Storage is never reset; a write is only committed outside reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_w_hs && w_aw_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[w_aw_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_hit ? r_mem[w_ar_idx] : '0;
                        r_rresp   <= w_ar_hit ? OKAY : SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_awaddr  <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_bvalid <= 1'b0;
                    if (awvalid && r_awready) begin
                        r_wstate  <= W_DATA;
                        r_awaddr  <= awaddr;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wstate <= W_RESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_aw_hit ? OKAY : SLVERR;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: strobed writes, reads, range errors,
// back-pressure, same-edge read/write and reset during a write.
module tb_axi_lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_lite_sram_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!awready && n < 20) begin
            tick();
            n++;
        end
        chk("aw_wait", {31'd0, awready}, 32'd1);
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        chk("ar_wait", {31'd0, arready}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        awaddr  = a;
        awvalid = 1'b1;
        wait_aw();
        tick();
        awvalid = 1'b0;
        chk("w_wready", {31'd0, wready}, 32'd1);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("w_bvalid", {31'd0, bvalid}, 32'd1);
        chk("w_bresp", {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp);
        araddr  = a;
        arvalid = 1'b1;
        wait_ar();
        tick();
        arvalid = 1'b0;
        chk("r_rvalid", {31'd0, rvalid}, 32'd1);
        chk("r_rdata", rdata, exp_d);
        chk("r_rresp", {30'd0, rresp}, {30'd0, exp_resp});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_done", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        // reset state
        @(negedge clk);
        tick();
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_arready", {31'd0, arready}, 32'd1);
        chk("post_rst_awready", {31'd0, awready}, 32'd1);

        // full word, then byte lane 1
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
        do_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        do_write(32'h8000_0011, 32'h0000_5500, 4'b0010, 2'b00);
        do_read (32'h8000_0010, 32'hDEAD_55EF, 2'b00);

        // upper halfword with wvalid raised together with awvalid
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
        awaddr = 32'h8000_0012; awvalid = 1'b1;
        wdata = 32'h1234_0000; wstrb = 4'b1100; wvalid = 1'b1;
        chk("early_w_wready", {31'd0, wready}, 32'd0);
        tick();
        awvalid = 1'b0;
        chk("early_w_wready_after_aw", {31'd0, wready}, 32'd1);
        chk("early_w_no_b", {31'd0, bvalid}, 32'd0);
        tick();
        wvalid = 1'b0;
        chk("early_w_bvalid", {31'd0, bvalid}, 32'd1);
        chk("early_w_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h8000_0010, 32'h1234_BEEF, 2'b00);

        // out of range, and no aliasing of the write onto first/last word
        do_read (32'h7FFF_FFFC, 32'h0000_0000, 2'b10);
        do_read (32'h8000_1000, 32'h0000_0000, 2'b10);
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'b1111, 2'b00);
        do_write(32'h8000_0FFC, 32'hA5A5_1234, 4'b1111, 2'b00);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        do_read (32'h8000_0FFC, 32'hA5A5_1234, 2'b00);
        do_read (32'h8000_0000, 32'h0BAD_F00D, 2'b00);

        // read back-pressure
        araddr = 32'h8000_0010; arvalid = 1'b1;
        wait_ar();
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
            chk("bp_rdata", rdata, 32'h1234_BEEF);
            chk("bp_arready", {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("bp_r_release", {31'd0, rvalid}, 32'd0);
        chk("bp_r_arready", {31'd0, arready}, 32'd1);

        // write back-pressure
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wait_aw();
        tick();
        awvalid = 1'b0;
        wdata = 32'h55AA_55AA; wstrb = 4'b1111; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
            chk("bp_awready", {31'd0, awready}, 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp_b_release", {31'd0, bvalid}, 32'd0);
        chk("bp_b_awready", {31'd0, awready}, 32'd1);

        // empty strobe
        do_write(32'h8000_0020, 32'h1111_2222, 4'b0000, 2'b00);
        do_read (32'h8000_0020, 32'h55AA_55AA, 2'b00);

        // read and write hitting the same word on the same edge
        do_write(32'h8000_0030, 32'h1111_1111, 4'b1111, 2'b00);
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wait_aw();
        tick();
        awvalid = 1'b0;
        wdata = 32'h2222_2222; wstrb = 4'b1111; wvalid = 1'b1;
        araddr = 32'h8000_0030; arvalid = 1'b1;
        chk("same_arready", {31'd0, arready}, 32'd1);
        tick();
        wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rvalid", {31'd0, rvalid}, 32'd1);
        chk("same_rdata_old", rdata, 32'h1111_1111);
        chk("same_bvalid", {31'd0, bvalid}, 32'd1);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0030, 32'h2222_2222, 2'b00);

        // reset between AW and W
        do_write(32'h8000_0040, 32'hCAFE_0001, 4'b1111, 2'b00);
        awaddr = 32'h8000_0040; awvalid = 1'b1;
        wait_aw();
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; wvalid = 1'b1;
        tick();
        chk("mid_rst_ready", {29'd0, arready, awready, wready}, 32'd0);
        chk("mid_rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
        rst_n = 1'b1;
        wvalid = 1'b0;
        tick();
        chk("mid_rst_arready", {31'd0, arready}, 32'd1);
        chk("mid_rst_awready", {31'd0, awready}, 32'd1);
        chk("mid_rst_wready", {31'd0, wready}, 32'd0);
        do_read(32'h8000_0040, 32'hCAFE_0001, 2'b00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
